// File: rtl/alu_pipe.sv
// Two-stage pipelined ALU with N/Z/C/V flags and valid/ready handshakes on both sides.
// Define ALU_SAT_EN to make ADD/SUB saturate instead of wrapping.
module alu_pipe #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic [2:0]       op_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] alu_o,
  output logic [3:0]       flags_o
);

  localparam int SHAMT_W = $clog2(WIDTH) + 1;
  localparam int MSB     = WIDTH - 1;
  localparam logic [WIDTH:0] WLIM = (WIDTH+1)'(WIDTH);

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_SHL = 3'b010,
    OP_SHR = 3'b011,
    OP_AND = 3'b100,
    OP_OR  = 3'b101,
    OP_XOR = 3'b110,
    OP_EQ  = 3'b111
  } op_e;

  logic             s1_valid;
  op_e              s1_op;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  logic             s2_valid;

  logic             adv1;
  logic             adv2;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;
  logic             b_big;
  logic [WIDTH-1:0] res;
  logic             c_flag;
  logic             v_flag;

  assign adv2        = !s2_valid || out_ready_i;
  assign adv1        = !s1_valid || adv2;
  assign in_ready_o  = adv1 && !reset;
  assign out_valid_o = s2_valid;

  assign sum   = {1'b0, s1_a} + {1'b0, s1_b};
  assign diff  = {1'b0, s1_a} - {1'b0, s1_b};
  assign b_big = ({1'b0, s1_b} >= WLIM);

  always_comb begin
    res    = '0;
    c_flag = 1'b0;
    v_flag = 1'b0;
    unique case (s1_op)
      OP_ADD: begin
        res    = sum[WIDTH-1:0];
        c_flag = sum[WIDTH];
        v_flag = (s1_a[MSB] == s1_b[MSB]) && (sum[MSB] != s1_a[MSB]);
`ifdef ALU_SAT_EN
        if (c_flag) res = '1;
`endif
      end
      OP_SUB: begin
        res    = diff[WIDTH-1:0];
        c_flag = diff[WIDTH];
        v_flag = (s1_a[MSB] != s1_b[MSB]) && (diff[MSB] != s1_a[MSB]);
`ifdef ALU_SAT_EN
        if (c_flag) res = '0;
`endif
      end
      OP_SHL: res = b_big ? '0 : (s1_a << s1_b[SHAMT_W-1:0]);
      OP_SHR: res = b_big ? '0 : (s1_a >> s1_b[SHAMT_W-1:0]);
      OP_AND: res = s1_a & s1_b;
      OP_OR:  res = s1_a | s1_b;
      OP_XOR: res = s1_a ^ s1_b;
      OP_EQ:  res = {{(WIDTH-1){1'b0}}, (s1_a == s1_b)};
    endcase
  end

  // S1 reloads whenever it can pass its contents on; operands are captured only on accept.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_op    <= OP_ADD;
      s1_a     <= '0;
      s1_b     <= '0;
    end else if (adv1) begin
      s1_valid <= in_valid_i;
      if (in_valid_i) begin
        s1_op <= op_e'(op_i);
        s1_a  <= i_a;
        s1_b  <= i_b;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s2_valid <= 1'b0;
      alu_o    <= '0;
      flags_o  <= '0;
    end else if (adv2) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        alu_o   <= res;
        flags_o <= {res[MSB], (res == '0), c_flag, v_flag};
      end
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe (WIDTH=8): directed vectors, stall, reset and random traffic
// scored against an arithmetic reference model.
module tb_alu_pipe;

  localparam logic [2:0] ADD = 3'd0, SUB = 3'd1, SHL = 3'd2, SHR = 3'd3;
  localparam logic [2:0] AND_ = 3'd4, OR_ = 3'd5, XOR_ = 3'd6, EQ = 3'd7;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] a, b;
  logic [2:0] op;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] alu;
  logic [3:0] flags;

  alu_pipe #(.WIDTH(8)) dut (
    .clk(clk), .reset(reset),
    .in_valid_i(in_valid), .in_ready_o(in_ready),
    .i_a(a), .i_b(b), .op_i(op),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .alu_o(alu), .flags_o(flags)
  );

  always #5 clk = ~clk;

  typedef struct { logic [2:0] op; logic [7:0] a; logic [7:0] b; logic [7:0] r; logic [3:0] f; } vec_t;
  typedef struct { logic [7:0] r; logic [3:0] f; } exp_t;

  exp_t        exp_q[$];
  int          passed = 0;
  int          total = 0;
  int          acc_n = 0;
  int unsigned cyc = 0;
  int unsigned last_acc = 0;
  bit          rnd_done;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act === expv) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
  endtask

  function automatic exp_t model(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y);
    int   ua, ub, sa, sb, r;
    bit   c, v;
    exp_t e;
    ua = int'(x); ub = int'(y);
    sa = (ua >= 128) ? ua - 256 : ua;
    sb = (ub >= 128) ? ub - 256 : ub;
    c = 1'b0; v = 1'b0; r = 0;
    case (o)
      ADD: begin
        c = (ua + ub) > 255;
        r = (ua + ub) % 256;
        v = (sa + sb > 127) || (sa + sb < -128);
`ifdef ALU_SAT_EN
        if (c) r = 255;
`endif
      end
      SUB: begin
        c = ua < ub;
        r = (ua - ub + 256) % 256;
        v = (sa - sb > 127) || (sa - sb < -128);
`ifdef ALU_SAT_EN
        if (c) r = 0;
`endif
      end
      SHL:  r = (ub >= 8) ? 0 : (ua * (1 << ub)) % 256;
      SHR:  r = (ub >= 8) ? 0 : ua / (1 << ub);
      AND_: r = ua & ub;
      OR_:  r = ua | ub;
      XOR_: r = ua ^ ub;
      default: r = (ua == ub) ? 1 : 0;
    endcase
    e.r = r[7:0];
    e.f = {r >= 128, r == 0, c, v};
    return e;
  endfunction

  // Scoreboard: whatever is presented must match the oldest outstanding result, stalled or not.
  always @(negedge clk) begin
    if (!reset && out_valid) begin
      if (exp_q.size() == 0) chk("unexpected_out_valid", 1, 0);
      else begin
        chk("result", alu, exp_q[0].r);
        chk("flags", flags, exp_q[0].f);
        if (out_ready) void'(exp_q.pop_front());
      end
    end
  end

  // Call just after a rising edge; returns 1 time unit after the accepting edge.
  task automatic send(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y, input exp_t e);
    bit done = 1'b0;
    op = o; a = x; b = y; in_valid = 1'b1;
    for (int k = 0; k < 100 && !done; k++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk);
        exp_q.push_back(e);
        last_acc = cyc;
        acc_n++;
        done = 1'b1;
      end
    end
    #1;
    if (!done) chk("accept_timeout", 0, 1);
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 300 && (exp_q.size() != 0 || out_valid); k++) @(negedge clk);
    chk("drain", exp_q.size(), 0);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        vt[14];
    exp_t        e;
    int unsigned first_acc;
    bit          seen;
    logic [2:0]  ro;
    logic [7:0]  rx, ry;

    vt[0]  = '{ADD,  8'hF0, 8'h20, 8'h10, 4'b0010};
`ifdef ALU_SAT_EN
    vt[0]  = '{ADD,  8'hF0, 8'h20, 8'hFF, 4'b1010};
`endif
    vt[1]  = '{ADD,  8'h7F, 8'h01, 8'h80, 4'b1001};
    vt[2]  = '{SUB,  8'h03, 8'h05, 8'hFE, 4'b1010};
`ifdef ALU_SAT_EN
    vt[2]  = '{SUB,  8'h03, 8'h05, 8'h00, 4'b0110};
`endif
    vt[3]  = '{SUB,  8'h05, 8'h05, 8'h00, 4'b0100};
    vt[4]  = '{SHL,  8'h81, 8'h01, 8'h02, 4'b0000};
    vt[5]  = '{SHL,  8'h81, 8'h08, 8'h00, 4'b0100};
    vt[6]  = '{SHR,  8'h80, 8'h07, 8'h01, 4'b0000};
    vt[7]  = '{SHR,  8'h80, 8'hFF, 8'h00, 4'b0100};
    vt[8]  = '{EQ,   8'h5A, 8'h5A, 8'h01, 4'b0000};
    vt[9]  = '{EQ,   8'h5A, 8'h5B, 8'h00, 4'b0100};
    vt[10] = '{AND_, 8'hF0, 8'h3C, 8'h30, 4'b0000};
    vt[11] = '{XOR_, 8'hFF, 8'h0F, 8'hF0, 4'b1000};
    vt[12] = '{OR_,  8'h0F, 8'h30, 8'h3F, 4'b0000};
    vt[13] = '{SUB,  8'h80, 8'h01, 8'h7F, 4'b0001};

    reset = 1'b1; in_valid = 1'b0; op = '0; a = '0; b = '0; out_ready = 1'b1;
    #3;
    chk("reset_out_valid", out_valid, 0);
    chk("reset_alu", alu, 0);
    chk("reset_flags", flags, 0);
    chk("reset_in_ready", in_ready, 0);
    @(posedge clk); @(posedge clk); #3 reset = 1'b0;
    @(negedge clk);
    chk("ready_after_release", in_ready, 1);
    @(posedge clk); #1;

    // Directed vectors, back to back at full rate
    first_acc = 0;
    for (int i = 0; i < 14; i++) begin
      e.r = vt[i].r; e.f = vt[i].f;
      send(vt[i].op, vt[i].a, vt[i].b, e);
      if (i == 0) first_acc = last_acc;
    end
    idle();
    chk("throughput", last_acc - first_acc, 13);
    drain();

    // Output stall with a stream of four commands
    out_ready = 1'b0; acc_n = 0;
    fork
      begin
        send(ADD, 8'h11, 8'h22, model(ADD, 8'h11, 8'h22));
        send(SUB, 8'h10, 8'h20, model(SUB, 8'h10, 8'h20));
        send(XOR_, 8'hAA, 8'h55, model(XOR_, 8'hAA, 8'h55));
        send(SHR, 8'hC3, 8'h02, model(SHR, 8'hC3, 8'h02));
        idle();
      end
      begin
        @(posedge clk); @(posedge clk);
        for (int k = 0; k < 3; k++) begin
          @(negedge clk);
          chk("stall_in_ready", in_ready, 0);
          chk("stall_accepts", acc_n, 2);
          chk("stall_out_valid", out_valid, 1);
          if (k < 2) @(posedge clk);
        end
        @(posedge clk); #1 out_ready = 1'b1;
      end
    join
    drain();
    chk("stall_all_accepted", acc_n, 4);

    // Random traffic with random backpressure
    rnd_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 150; i++) begin
          ro = 3'($urandom_range(0, 7));
          rx = 8'($urandom);
          ry = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'($urandom_range(0, 9));
          send(ro, rx, ry, model(ro, rx, ry));
          if ($urandom_range(0, 4) == 0) begin
            idle();
            @(posedge clk); #1;
          end
        end
        idle();
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk); #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
        out_ready = 1'b1;
      end
    join
    drain();

    // Reset with both stages full
    out_ready = 1'b0;
    send(ADD, 8'hF0, 8'h20, model(ADD, 8'hF0, 8'h20));
    send(XOR_, 8'h0F, 8'h01, model(XOR_, 8'h0F, 8'h01));
    idle();
    #2 reset = 1'b1;
    #1;
    chk("midreset_out_valid", out_valid, 0);
    chk("midreset_alu", alu, 0);
    chk("midreset_flags", flags, 0);
    chk("midreset_in_ready", in_ready, 0);
    exp_q.delete();
    @(posedge clk); #3 reset = 1'b0;
    @(negedge clk);
    chk("rerelease_in_ready", in_ready, 1);
    chk("rerelease_out_valid", out_valid, 0);
    out_ready = 1'b1;
    @(posedge clk); #1;
    send(ADD, 8'h7F, 8'h01, model(ADD, 8'h7F, 8'h01));
    idle();
    @(negedge clk);
    chk("latency_not_early", out_valid, 0);
    seen = 1'b0;
    for (int k = 0; k < 2 && !seen; k++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    chk("latency", seen, 1);
    drain();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
